data_mem_mmio: RTL and testbench
================================

Name: data_mem_mmio

Overview:
Data-side responder for the CPU's data memory port. It provides word-organised RAM with byte write enables and a registered read. It also decodes a memory-mapped I/O region containing a GPIO output register, a free-running cycle counter and an 8N1 UART transmitter. It sits between the CPU's data port and the top-level pins.

Parameters:
DEPTH, 1024, RAM size in 32-bit words; power of two, >= 2.
CLKS_PER_BIT, 868, clock cycles per UART bit; >= 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
data_addr  in  32  byte address; bits [1:0] ignored (word-aligned access).
data_wr  in  32  write data, already lane-shifted by the CPU.
data_wr_en  in  4  per-byte write enable; bit i enables byte lane i; 0 means no write.
data_rd  out  32  registered read data for the previous cycle's data_addr.
gpio_out  out  32  GPIO output register.
uart_tx  out  1  UART serial line; idles high.

Behaviour:
- Address decode:
  - RAM when data_addr[31:28]==4'h0; word index data_addr[log2(DEPTH)+1:2]; higher bits alias.
  - IO when data_addr[31:28]==4'hF.
  - All other regions: read 0, writes ignored.
- IO map (offset data_addr[3:2]; IO address bits [27:4] ignored, so IO aliases):
  - 0xF000_0000 GPIO: RW; byte enables honoured.
  - 0xF000_0004 CYCLE: RO; writes ignored.
  - 0xF000_0008 UART_TX: a write with data_wr_en[0]=1 sends data_wr[7:0]; a read returns STATUS.
  - 0xF000_000C STATUS: read {30'b0, ovf, busy}; a write with data_wr_en[0]=1 and data_wr[1]=1 clears ovf.
- Read timing:
  - data_rd <= decode(data_addr) at every rising edge, regardless of data_wr_en.
  - Latency exactly 1 cycle.
  - A read of an address being written in the same cycle returns the old value (read-before-write).
  - CYCLE read returns the pre-increment value.
- Writes commit at the rising edge on which data_wr_en != 0. Only enabled lanes change.
- RAM contents are not affected by rst; simulation initial contents are 0.
- CYCLE: 32-bit counter.
  - 0 in the first cycle after rst deasserts.
  - +1 every cycle; wraps 0xFFFF_FFFF -> 0.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1, busy=0. An accepted TX write latches the byte and moves to START on the same edge; busy=1 from the next cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; 3-bit index -> STOP after bit 7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles -> IDLE. busy falls on entry to IDLE.
  - busy is high for exactly 10*CLKS_PER_BIT cycles per byte.
  - A TX write while busy=1 is dropped and sets sticky ovf; the frame in flight is unaffected.
  - A TX write on the first IDLE cycle after STOP is accepted.
  - Simultaneous ovf set and clear: set wins.
- Reset, including mid-frame:
  - Next cycle: data_rd=0, gpio_out=0, CYCLE=0, uart_tx=1, busy=0, ovf=0, FSM=IDLE.
  - A partial frame is abandoned.

Test Plan:
- RAM byte lanes: store 0x12345678 to 0x10 en=1111, then store 0x00AB0000 en=0100, then read 0x10 -> data_rd=0x12AB5678 one cycle after the address is presented.
- Aliasing and latency (DEPTH=1024): write 0xCAFEF00D to 0x10, read 0x1010 -> 0xCAFEF00D; read 0x5000_0000 -> 0; a read in the same cycle as a write returns the old value.
- CYCLE: deassert rst, present 0xF000_0004 in post-reset cycle 5 -> data_rd=5 in cycle 6; force the counter to 0xFFFF_FFFF -> wraps to 0.
- UART frame (CLKS_PER_BIT=4): write 0xA5 to 0xF000_0008 -> uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy high for exactly 40 cycles; STATUS reads 1 during the frame, 0 after.
- Overflow: second TX write while busy -> frame unchanged, STATUS=3; write 0x2 to 0xF000_000C -> STATUS=1; back-to-back write on the first IDLE cycle starts a new frame with no ovf.
- Reset mid-frame (during DATA bit 3) with gpio_out=0xFFFF_0000: next cycle uart_tx=1, busy=0, gpio_out=0, data_rd=0; RAM word 0x10 still reads 0x12AB5678.

Source files
------------

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: responder for the CPU data port. Word-organised RAM with
// byte enables and registered read, plus an I/O region holding a GPIO
// output register, a free-running cycle counter and an 8N1 UART transmitter.
module data_mem_mmio #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic [31:0] gpio_out,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_IO  = 4'hF;

  localparam logic [1:0] OFF_GPIO   = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TX     = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic          sel_ram;
  logic          sel_io;
  logic [1:0]    io_off;
  logic [AW-1:0] word_idx;
  logic          tx_wr;
  logic          ovf_clr;
  logic          unused_addr_bits;

  assign sel_ram  = (data_addr[31:28] == REGION_RAM);
  assign sel_io   = (data_addr[31:28] == REGION_IO);
  assign io_off   = data_addr[3:2];
  assign word_idx = data_addr[AW+1:2];

  // A TX write is any write touching lane 0 of the TX register
  assign tx_wr   = sel_io && (io_off == OFF_TX) && data_wr_en[0];
  assign ovf_clr = sel_io && (io_off == OFF_STATUS) && data_wr_en[0] && data_wr[1];

  // Low address bits and high alias bits are don't-care by design
  assign unused_addr_bits = ^data_addr;

  // ---------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // Byte-lane RAM writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wr_en[i]) begin
          mem[word_idx][8*i +: 8] <= data_wr[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // GPIO register
  // ---------------------------------------------------------------------

  // GPIO output register with per-lane write enables
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
    end else if (sel_io && (io_off == OFF_GPIO)) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wr_en[i]) begin
          gpio_out[8*i +: 8] <= data_wr[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------
  logic [31:0] cycle_cnt;

  // Free-running counter, zero in the first cycle after reset, wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------
  uart_state_t   state;
  uart_state_t   state_next;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    tx_byte;
  logic [7:0]    tx_byte_next;
  logic          ovf;
  logic          ovf_next;
  logic          tx_next;
  logic          bit_done;
  logic          busy;

  assign bit_done = (clk_cnt == BIT_LAST);
  assign busy     = (state != S_IDLE);

  // UART state register; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      ovf     <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
      tx_byte <= tx_byte_next;
      ovf     <= ovf_next;
      uart_tx <= tx_next;
    end
  end

  // UART next state; line level is derived from the next state so the
  // registered output lines up with the state it belongs to
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    tx_byte_next = tx_byte;
    ovf_next     = ovf;
    tx_next      = 1'b1;

    case (state)
      S_IDLE: begin
        if (tx_wr) begin
          state_next   = S_START;
          clk_cnt_next = '0;
          bit_idx_next = '0;
          tx_byte_next = data_wr[7:0];
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next   = S_DATA;
          clk_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_next   = S_IDLE;
          clk_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Overflow flag: a dropped TX write beats a simultaneous clear
    if (ovf_clr) begin
      ovf_next = 1'b0;
    end
    if (tx_wr && (state != S_IDLE)) begin
      ovf_next = 1'b1;
    end

    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = tx_byte_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [31:0] rd_next;
  logic [31:0] status_word;

  assign status_word = {30'b0, ovf, busy};

  // Read mux sees pre-edge state, giving read-before-write behaviour
  always_comb begin
    rd_next = '0;
    if (sel_ram) begin
      rd_next = mem[word_idx];
    end else if (sel_io) begin
      case (io_off)
        OFF_GPIO:  rd_next = gpio_out;
        OFF_CYCLE: rd_next = cycle_cnt;
        default:   rd_next = status_word;
      endcase
    end
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd <= '0;
    end else begin
      data_rd <= rd_next;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: vector table, hand-written UART/overflow/reset sequences
// and randomized traffic checked against a time-based reference model.
module tb_data_mem_mmio;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CPB   = 4;
  localparam int          CPB_I = 4;
  localparam int          FRAME = 10 * CPB_I;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  data_wr_en = '0;
  logic [31:0] data_rd;
  logic [31:0] gpio_out;
  logic        uart_tx;

  data_mem_mmio #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en),
    .data_rd    (data_rd),
    .gpio_out   (gpio_out),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory array, registers, and the UART described as
  // "frame started at cycle m_fs" rather than as a state machine.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_gpio = '0;
  logic [31:0] m_cyc_base = '0;
  int          m_t = 0;
  bit          m_fvalid = 1'b0;
  int          m_fs = 0;
  logic [7:0]  m_byte = '0;
  bit          m_ovf = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wr;
    logic [3:0]  en;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return m_fvalid && (c >= m_fs) && (c < m_fs + FRAME);
  endfunction

  function automatic logic m_tx(input int c);
    int slot;
    if (!m_busy(c)) return 1'b1;
    slot = (c - m_fs) / CPB_I;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[3'(slot - 1)];
    return 1'b1;
  endfunction

  // Apply one access to the model for the current cycle m_t
  task automatic model_step(input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] e, output logic [31:0] rd);
    bit         set_o;
    bit         clr_o;
    logic [9:0] wi;
    logic [1:0] off;
    wi    = a[11:2];
    off   = a[3:2];
    rd    = '0;
    set_o = 1'b0;
    clr_o = 1'b0;
    if (a[31:28] == 4'h0) begin
      rd = m_mem[wi];
    end else if (a[31:28] == 4'hF) begin
      case (off)
        2'd0:    rd = m_gpio;
        2'd1:    rd = 32'(m_t) + m_cyc_base;
        default: rd = {30'b0, m_ovf, m_busy(m_t)};
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        if (a[31:28] == 4'h0) m_mem[wi][8*i +: 8] = w[8*i +: 8];
        else if (a[31:28] == 4'hF && off == 2'd0) m_gpio[8*i +: 8] = w[8*i +: 8];
      end
    end
    if (a[31:28] == 4'hF && e[0]) begin
      if (off == 2'd2) begin
        if (m_busy(m_t)) begin
          set_o = 1'b1;
        end else begin
          m_fvalid = 1'b1;
          m_fs     = m_t + 1;
          m_byte   = w[7:0];
        end
      end
      if (off == 2'd3 && w[1]) clr_o = 1'b1;
    end
    if (set_o) m_ovf = 1'b1;
    else if (clr_o) m_ovf = 1'b0;
    m_t++;
  endtask

  // One bus cycle: drive at negedge, compare the result at the next negedge
  task automatic access(input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] e, input string tag);
    logic [31:0] exp_rd;
    data_addr  = a;
    data_wr    = w;
    data_wr_en = e;
    model_step(a, w, e, exp_rd);
    @(negedge clk);
    chk({tag, ".rd"}, data_rd, exp_rd);
    chk({tag, ".gpio"}, gpio_out, m_gpio);
    chk({tag, ".tx"}, {31'b0, uart_tx}, {31'b0, m_tx(m_t)});
  endtask

  task automatic idle(input string tag);
    access(32'h5000_0000, 32'h0, 4'h0, tag);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_wr_en = '0;
    data_addr  = '0;
    data_wr    = '0;
    @(negedge clk);
    rst        = 1'b0;
    m_t        = 0;
    m_cyc_base = '0;
    m_fvalid   = 1'b0;
    m_ovf      = 1'b0;
    m_gpio     = '0;
    chk("rst.rd", data_rd, 32'h0);
    chk("rst.gpio", gpio_out, 32'h0);
    chk("rst.tx", {31'b0, uart_tx}, 32'h1);
  endtask

  initial begin
    logic [9:0]  frame_bits;
    logic        samp [45];
    int          busy_cnt;
    logic [31:0] a;
    int          sel;

    vecs[0]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h00AB_0000, 4'h4, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h12AB_5678};
    vecs[3]  = '{32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{32'h0000_1020, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D};
    vecs[5]  = '{32'h5000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[6]  = '{32'h0000_0020, 32'h1111_1111, 4'hF, 1'b1, 32'hCAFE_F00D};
    vecs[7]  = '{32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h1111_1111};
    vecs[8]  = '{32'hF000_0000, 32'hFFFF_0000, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{32'hF000_0000, 32'h0,         4'h0, 1'b1, 32'hFFFF_0000};
    vecs[10] = '{32'hF000_0000, 32'h0000_00AA, 4'h1, 1'b1, 32'hFFFF_0000};
    vecs[11] = '{32'hF000_1230, 32'h0,         4'h0, 1'b1, 32'hFFFF_00AA};
    vecs[12] = '{32'hF000_000C, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[13] = '{32'hF000_0008, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[14] = '{32'h3000_0010, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[15] = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h12AB_5678};
    vecs[16] = '{32'hF000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[17] = '{32'hF000_0014, 32'h0,         4'h0, 1'b0, 32'h0};

    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;

    repeat (2) @(negedge clk);
    do_reset();

    // Cycle counter: read in post-reset cycle 5 returns 5
    repeat (5) idle("cyc_idle");
    access(32'hF000_0004, 32'h0, 4'h0, "cyc5");
    chk("cyc5.const", data_rd, 32'd5);

    // Vector table
    for (int i = 0; i < 18; i++) begin
      access(vecs[i].addr, vecs[i].wr, vecs[i].en, $sformatf("vec%0d", i));
      if (vecs[i].chk) chk($sformatf("vec%0d.const", i), data_rd, vecs[i].exp);
    end

    // Counter wrap: deposit all-ones, then observe rollover
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    m_cyc_base = 32'hFFFF_FFFF - 32'(m_t);
    access(32'hF000_0004, 32'h0, 4'h0, "wrap0");
    chk("wrap0.const", data_rd, 32'hFFFF_FFFF);
    access(32'hF000_0004, 32'h0, 4'h0, "wrap1");
    chk("wrap1.const", data_rd, 32'h0);

    // UART frame for 0xA5
    frame_bits = 10'b1_1010_0101_0;
    access(32'hF000_0008, 32'h0000_00A5, 4'h1, "tx_a5");
    samp[0]  = uart_tx;
    busy_cnt = 0;
    for (int k = 1; k < 45; k++) begin
      access(32'hF000_000C, 32'h0, 4'h0, "frame");
      samp[k] = uart_tx;
      if (data_rd[0]) busy_cnt++;
    end
    for (int k = 0; k < 45; k++) begin
      chk($sformatf("frame_bit%0d", k), {31'b0, samp[k]},
          {31'b0, (k < FRAME) ? frame_bits[k / CPB_I] : 1'b1});
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(FRAME));
    chk("status_after", data_rd, 32'h0);

    // Overflow: second write dropped, clear, then back-to-back on first idle cycle
    access(32'hF000_0008, 32'h0000_003C, 4'h1, "ovf_tx1");
    repeat (3) idle("ovf_idle");
    access(32'hF000_0008, 32'h0000_0055, 4'h1, "ovf_tx2");
    access(32'hF000_000C, 32'h0, 4'h0, "ovf_st");
    chk("ovf_status3", data_rd, 32'h3);
    access(32'hF000_000C, 32'h0000_0002, 4'h1, "ovf_clr");
    chk("ovf_clr_rd", data_rd, 32'h3);
    access(32'hF000_000C, 32'h0, 4'h0, "ovf_st2");
    chk("ovf_status1", data_rd, 32'h1);
    repeat (33) idle("ovf_wait");
    access(32'hF000_0008, 32'h0000_0081, 4'h1, "b2b_tx");
    chk("b2b_idle_status", data_rd, 32'h0);
    access(32'hF000_000C, 32'h0, 4'h0, "b2b_st");
    chk("b2b_status1", data_rd, 32'h1);
    repeat (45) idle("b2b_frame");

    // Reset during DATA bit 3
    access(32'hF000_0000, 32'hFFFF_0000, 4'hF, "mr_gpio");
    access(32'hF000_0008, 32'h0000_005A, 4'h1, "mr_tx");
    repeat (17) idle("mr_run");
    chk("mr_bit3", {31'b0, uart_tx}, 32'h1);
    chk("mr_gpio_set", gpio_out, 32'hFFFF_0000);
    do_reset();
    access(32'hF000_000C, 32'h0, 4'h0, "mr_st");
    chk("mr_status0", data_rd, 32'h0);
    access(32'h0000_0010, 32'h0, 4'h0, "mr_ram");
    chk("mr_ram_kept", data_rd, 32'h12AB_5678);
    repeat (45) idle("mr_quiet");

    // Randomized traffic over a small aliased RAM window and the IO map
    for (int i = 0; i < 16; i++) access(32'(i * 4), $urandom(), 4'hF, "pre");
    for (int n = 0; n < 600; n++) begin
      a   = $urandom();
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        a[31:28] = 4'h0;
        a[11:6]  = '0;
      end else if (sel <= 7) begin
        a[31:28] = 4'hF;
        a[3:2]   = 2'(sel - 4);
      end else if (sel == 8) begin
        a[31:28] = 4'($urandom_range(1, 14));
      end
      if (sel == 9) idle("rnd_idle");
      else access(a, $urandom(), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
